addbit_serial_ctrl: RTL and testbench
=====================================

Name: addbit_serial_ctrl

Overview:
- Bit-serial add/subtract sequencer built around one instance of the team's 1-bit full-adder cell `addbit` (ports cin, a, b, sum, cout).
- Accepts a WIDTH-bit operand pair over a valid/ready handshake.
- Feeds the cell one bit per cycle, LSB first, through a registered carry.
- Returns the sum, carry-out and signed-overflow flag over a second valid/ready handshake.
- Used wherever area matters more than latency; it replaces a WIDTH-bit ripple adder.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..64.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  1 = compute a - b, 0 = compute a + b; sampled with operands.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result, a ± b mod 2^WIDTH.
- cout  output  1  final carry-out; for subtract, 1 = no borrow.
- ovf  output  1  two's-complement overflow.

Behaviour:
- Interface decision: one clock, clk; reset rst is synchronous and active-high.
- FSM states: IDLE, RUN, DONE.
- Reset values: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, carry reg=0, bit counter=0.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge: latch a into shift reg A; latch (sub ? ~b : b) into shift reg B; carry reg<=sub; counter<=0; go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle the cell sees A[0], B[0] and the carry reg.
  - At the edge: cell sum is shifted into the result reg MSB side (result shifts right); carry reg<=cell cout; A and B shift right; counter++.
  - On the edge where counter==WIDTH-1: record carry-into-MSB (the carry reg value before the update) and go to DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - cout = final carry; ovf = carry-into-MSB XOR cout.
  - sum, cout and ovf are held stable until out_valid&&out_ready at an edge, then go to IDLE.
  - sum/cout/ovf keep their last values in IDLE.
- Latency: operands accepted at edge k; out_valid is high after edge k+WIDTH, i.e. exactly WIDTH cycles in RUN.
- Throughput: one operation per WIDTH+2 cycles minimum. There is no accept in the same cycle as the result handoff, because in_ready is only high in IDLE.
- Changes on a, b, sub or in_valid outside IDLE are ignored.
- Backpressure: out_ready low holds DONE indefinitely with all outputs stable.
- Counter width is clog2(WIDTH); no wrap beyond WIDTH-1.
- Reset mid-RUN or mid-DONE aborts the operation immediately: all outputs go to reset values on the next edge, and the result is discarded.
- rst has priority over any handshake in the same cycle.
- out_valid and in_ready are never high simultaneously.

Test Plan:
- WIDTH=8, add 0x0F+0x01 -> after 8 RUN cycles out_valid=1, sum=0x10, cout=0, ovf=0.
- Add 0xFF+0x01 -> sum=0x00, cout=1, ovf=0; add 0x7F+0x01 -> sum=0x80, cout=0, ovf=1.
- Sub 0x05-0x07 -> sum=0xFE, cout=0 (borrow), ovf=0; sub 0x80-0x01 -> sum=0x7F, cout=1, ovf=1.
- Backpressure: out_ready held low 5 cycles after DONE -> out_valid, sum and cout stable throughout. in_valid pulsed during the stall with a new pair -> ignored (in_ready=0). Release -> IDLE next cycle, then the new pair is accepted.
- Reset mid-RUN: assert rst at RUN cycle 4 of 0x55+0x2A -> next edge out_valid=0, in_ready=1, sum=0. A following 0x01+0x01 yields sum=0x02 with no residue of the aborted operation.
- Back-to-back: 20 random add/sub pairs, out_ready always 1, checked against a reference model. Each op takes exactly 10 cycles from accept to next in_ready.

Source files
------------

// File: rtl/addbit_serial_ctrl.sv
// Bit-serial add/subtract sequencer: one addbit cell walks the operands LSB first
// through a registered carry, with valid/ready handshakes on operands and result.

module addbit (
    input  logic cin,
    input  logic a,
    input  logic b,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module addbit_serial_ctrl_chk (
    input logic clk,
    input logic rst,
    input logic in_ready,
    input logic out_valid
);
    // Operand and result handshakes must never be offered together.
    a_hs_exclusive: assert property (@(posedge clk) disable iff (rst) !(in_ready && out_valid));
endmodule

module addbit_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             next_state_s;
    logic               accept_s;
    logic               last_bit_s;

    logic [WIDTH-1:0]   a_sh_r;
    logic [WIDTH-1:0]   b_sh_r;
    logic [WIDTH-2:0]   res_r;
    logic [WIDTH-1:0]   res_next_s;
    logic               carry_r;
    logic [CNT_W-1:0]   cnt_r;

    logic               cell_sum_s;
    logic               cell_cout_s;

    logic               in_ready_r;
    logic               out_valid_r;
    logic [WIDTH-1:0]   sum_r;
    logic               cout_r;
    logic               ovf_r;

    addbit u_cell (
        .cin  (carry_r),
        .a    (a_sh_r[0]),
        .b    (b_sh_r[0]),
        .sum  (cell_sum_s),
        .cout (cell_cout_s)
    );

    // Result bits enter at the MSB side; the oldest bit ends up at bit 0 after WIDTH shifts.
    assign res_next_s = {cell_sum_s, res_r};

    // Next-state and per-cycle control decode.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        last_bit_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid && in_ready_r) begin
                    accept_s     = 1'b1;
                    next_state_s = RUN;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == LAST_CNT) begin
                    last_bit_s   = 1'b1;
                    next_state_s = DONE;
                end else begin
                    next_state_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = DONE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Handshake outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            in_ready_r  <= (next_state_s == IDLE);
            out_valid_r <= (next_state_s == DONE);
        end
    end

    // Operand shifters, carry and bit counter; subtract is a + ~b + 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_r  <= '0;
            b_sh_r  <= '0;
            res_r   <= '0;
            carry_r <= 1'b0;
            cnt_r   <= '0;
        end else if (accept_s) begin
            a_sh_r  <= a;
            b_sh_r  <= sub ? ~b : b;
            carry_r <= sub;
            cnt_r   <= '0;
        end else if (state_r == RUN) begin
            a_sh_r  <= {1'b0, a_sh_r[WIDTH-1:1]};
            b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
            res_r   <= res_next_s[WIDTH-1:1];
            carry_r <= cell_cout_s;
            // Counter parks at the last index instead of wrapping.
            cnt_r   <= last_bit_s ? cnt_r : (cnt_r + CNT_ONE);
        end
    end

    // Result capture on the final bit; held through DONE and the following IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (last_bit_s) begin
            sum_r  <= res_next_s;
            cout_r <= cell_cout_s;
            ovf_r  <= carry_r ^ cell_cout_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;

    addbit_serial_ctrl_chk u_chk (
        .clk       (clk),
        .rst       (rst),
        .in_ready  (in_ready_r),
        .out_valid (out_valid_r)
    );

endmodule

// File: tb/tb_addbit_serial_ctrl.sv
// Directed bench for addbit_serial_ctrl at WIDTH=8 with a small reference model
// for the back-to-back random section.

module tb_addbit_serial_ctrl;
    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int n_cmp;
    int n_err;
    int cyc;

    addbit_serial_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: a + (sub ? ~b : b) + sub; overflow from operand/result sign rule.
    task automatic model(input logic [7:0] oa, ob, input logic os,
                         output logic [7:0] es, output logic ec, output logic eo);
        logic [7:0] bb;
        logic [8:0] full;
        bb   = os ? ~ob : ob;
        full = {1'b0, oa} + {1'b0, bb} + {8'd0, os};
        es   = full[7:0];
        ec   = full[8];
        eo   = (oa[7] == bb[7]) && (full[7] != oa[7]);
    endtask

    // One complete operation with out_ready high; entered and left at a negedge.
    task automatic run_op(input logic [7:0] oa, ob, input logic os,
                          input logic [7:0] es, input logic ec, eo, input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_rdy"}, in_ready, 1'b1);
        a = oa; b = ob; sub = os; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = ~oa; b = ~ob; sub = ~os;
        chk({tag, "_busy"}, in_ready, 1'b0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, n, 8);
        chk({tag, "_sum"}, sum, es);
        chk({tag, "_cout"}, cout, ec);
        chk({tag, "_ovf"}, ovf, eo);
        chk({tag, "_excl"}, in_ready, 1'b0);
        @(negedge clk);
        chk({tag, "_rel_ov"}, out_valid, 1'b0);
        chk({tag, "_rel_ir"}, in_ready, 1'b1);
    endtask

    initial begin
        logic [7:0] ra, rb, es;
        logic       rs, ec, eo;
        int         n, t, prev;

        n_cmp = 0; n_err = 0; cyc = 0;
        rst = 1'b1; in_valid = 1'b0; a = 8'h00; b = 8'h00; sub = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_sum", sum, 8'h00);
        chk("rst_cout", cout, 1'b0);
        chk("rst_ovf", ovf, 1'b0);

        run_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, "add_0f_01");
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "add_ff_01");
        run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "add_7f_01");
        run_op(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, "sub_05_07");
        run_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_80_01");

        // Backpressure: 0x12 + 0x34 held in DONE while a new pair is offered.
        out_ready = 1'b0;
        a = 8'h12; b = 8'h34; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_lat", n, 8);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                a = 8'h99; b = 8'h11; sub = 1'b1; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            chk("bp_valid", out_valid, 1'b1);
            chk("bp_sum", sum, 8'h46);
            chk("bp_cout", cout, 1'b0);
            chk("bp_in_ready", in_ready, 1'b0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("bp_still_valid", out_valid, 1'b1);
        chk("bp_still_sum", sum, 8'h46);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_rel_ov", out_valid, 1'b0);
        chk("bp_rel_ir", in_ready, 1'b1);
        chk("bp_idle_sum", sum, 8'h46);
        run_op(8'h99, 8'h11, 1'b0, 8'hAA, 1'b0, 1'b0, "bp_new");

        // Reset during RUN of 0x55 + 0x2A.
        a = 8'h55; b = 8'h2A; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("mr_running", in_ready, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mr_out_valid", out_valid, 1'b0);
        chk("mr_in_ready", in_ready, 1'b1);
        chk("mr_sum", sum, 8'h00);
        chk("mr_cout", cout, 1'b0);
        chk("mr_ovf", ovf, 1'b0);
        run_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, "post_rst");

        // Back-to-back random ops with in_valid held high; accepts 10 cycles apart.
        prev = 0;
        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom_range(1, 0));
            model(ra, rb, rs, es, ec, eo);
            a = ra; b = rb; sub = rs; in_valid = 1'b1;
            n = 0;
            while (!in_ready && n < 30) begin
                @(negedge clk);
                n++;
            end
            chk("b2b_rdy", in_ready, 1'b1);
            @(posedge clk);
            @(negedge clk);
            t = cyc;
            if (i > 0) chk("b2b_period", t - prev, 10);
            prev = t;
            a = ~ra; b = ~rb; sub = ~rs;
            n = 0;
            while (!out_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("b2b_lat", n, 8);
            chk("b2b_sum", sum, es);
            chk("b2b_cout", cout, ec);
            chk("b2b_ovf", ovf, eo);
        end
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
